alu_reservation_station: RTL and testbench
==========================================

Name: alu_reservation_station

Overview:
Operand-collecting issue buffer directly upstream of the integer ALU. Accepts decoded R/I-type ALU ops from dispatch, holding up to DEPTH entries. Captures missing source operands from the common data bus (CDB) by tag. Issues one fully-ready op per cycle into the ALU's lhs/rhs/funct3/funct7/uses_imm inputs, with a valid/ready handshake.

Parameters:
DATA_WIDTH, 64, operand and CDB data width; matches the ALU.
DEPTH, 4, number of entries; power of two, at least 2.
TAG_WIDTH, 4, producer/destination tag width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  synchronous clear of all entries, e.g. on mispredict.
in_valid  in  1  dispatch offers an op.
in_ready  out  1  at least one free entry.
in_funct3 / in_funct7 / in_uses_imm  in  3 / 7 / 1  op encoding, passed through unchanged.
in_lhs / in_rhs  in  DATA_WIDTH each  operand values; meaningful only when the matching _rdy is 1.
in_lhs_rdy / in_rhs_rdy  in  1 each  operand already present.
in_lhs_tag / in_rhs_tag  in  TAG_WIDTH each  producer tag for each operand not yet present.
in_dest_tag  in  TAG_WIDTH  destination tag of the op.
cdb_valid / cdb_tag / cdb_data  in  1 / TAG_WIDTH / DATA_WIDTH  result broadcast.
out_valid  out  1  an issued op is present; drives the ALU's lhs_valid and rhs_valid.
out_ready  in  1  ALU/pipeline accepts the op.
out_lhs / out_rhs  out  DATA_WIDTH each  issued operands.
out_funct3 / out_funct7 / out_uses_imm / out_dest_tag  out  3 / 7 / 1 / TAG_WIDTH  issued op fields.
count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rst=1): all entries invalid; the next cycle shows out_valid=0, in_ready=1, count=0, and all out_* data fields=0. Reset mid-operation discards everything, including an op being handshaken that cycle.
- flush=1: same effect as reset on the entries. A dispatch in the same cycle is dropped.
- Entry state: valid, funct3, funct7, uses_imm, dest_tag, lhs, lhs_rdy, lhs_tag, rhs, rhs_rdy, rhs_tag.
- Dispatch: on in_valid & in_ready, write the lowest-index free entry.
  - in_ready is computed from occupancy at the start of the cycle.
  - An entry freed by issue in the same cycle is not reusable until the next cycle, so when full, in_ready=0 even if out_ready=1.
- When uses_imm=1, rhs is treated as ready regardless of in_rhs_rdy.
- Dispatch/CDB collision: if cdb_valid and cdb_tag equals an incoming not-ready tag, the entry is written with cdb_data and the operand marked ready.
- Wakeup: each valid entry with a not-ready operand whose tag equals cdb_tag while cdb_valid captures cdb_data and sets the ready bit at the clock edge. Both operands may wake on the same broadcast.
- Ready entry: valid & lhs_rdy & rhs_rdy.
- Select: fixed priority, lowest-index ready entry. out_* are driven combinationally from that entry's registers.
  - out_valid=1 iff any entry is ready.
  - With no ready entry, all out_* data fields are 0.
- Issue completes on out_valid & out_ready; the selected entry is invalidated at the edge.
- out_* must stay stable while out_valid=1 and out_ready=0, unless a lower-index entry becomes ready. Fixed priority is allowed to switch the selection in that case; the ALU is combinational, so this is legal.
- count updates:
  - +1 on dispatch only; -1 on issue only.
  - Unchanged when dispatch and issue happen in the same cycle.
  - Saturation is impossible by construction.
- Latency: a fully-ready dispatched op can issue the cycle after dispatch. A CDB wakeup makes the op issuable the cycle after the broadcast.

Optional Feature:
Macro RS_CDB_WAKEUP_BYPASS_EN.
- Defined: an entry whose only missing operands match the current cycle's cdb_tag (with cdb_valid) counts as ready that same cycle, and its out_lhs/out_rhs are muxed from cdb_data. Wakeup-to-issue latency is 0 cycles.
- Undefined: wakeup-to-issue latency is 1 cycle, and out_* come only from registered state.
- Dispatch behaviour is identical in both builds.

Decomposition:
- Package alu_rs_pkg holds:
  - rs_entry_t packed struct with the fields above;
  - funct3 localparams ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SR=5, OR=6, AND=7;
  - funct7 localparams F7_BASE=7'h00, F7_ALT=7'h20.
- One sub-module, alu_rs_entry: a single slot holding the entry register, CDB tag compare/capture logic and the ready output. The top level instantiates DEPTH of them plus the allocate/select priority encoders.

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, count=0. Dispatch ADD with lhs=5, rhs=7, both ready → next cycle out_valid=1, out_lhs=5, out_rhs=7, funct3=0.
- Dispatch SUB (funct7=0x20) with lhs_tag=3 not ready and out_ready=1; two cycles later cdb_valid, tag=3, data=0x10 → out_valid rises the cycle after the CDB, with out_lhs=0x10. With RS_CDB_WAKEUP_BYPASS_EN it rises in the CDB cycle itself.
- Fill all 4 entries with waiting ops → in_ready=0, count=4. Issue one with out_ready=1 in that cycle → in_ready still 0 that cycle, 1 the next, count=3.
- Dispatch an op with rhs_tag=9 in the same cycle as a CDB broadcast for tag 9, data=0xAB → captured; op issues next cycle with out_rhs=0xAB.
- Entries 0 and 2 both ready with out_ready=0 → out shows entry 0, stable for 3 cycles. Then out_ready=1 → entry 0 issues, entry 2 issues the following cycle.
- Three entries occupied, assert flush together with in_valid → the next cycle shows count=0 and out_valid=0; the dispatched op is absent.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared widths, ALU op encodings and the reservation-station entry layout
package alu_rs_pkg;
    localparam int RS_DATA_W = 64;
    localparam int RS_TAG_W = 4;
    localparam logic [2:0] ADD = 3'd0;
    localparam logic [2:0] SLL = 3'd1;
    localparam logic [2:0] SLT = 3'd2;
    localparam logic [2:0] SLTU = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] SR = 3'd5;
    localparam logic [2:0] OR = 3'd6;
    localparam logic [2:0] AND = 3'd7;
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT = 7'h20;
    typedef struct packed {
        logic valid;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic uses_imm;
        logic [RS_TAG_W-1:0] dest_tag;
        logic [RS_DATA_W-1:0] lhs;
        logic lhs_rdy;
        logic [RS_TAG_W-1:0] lhs_tag;
        logic [RS_DATA_W-1:0] rhs;
        logic rhs_rdy;
        logic [RS_TAG_W-1:0] rhs_tag;
    } rs_entry_t;
endpackage

// File: rtl/alu_rs_entry.sv
// alu_rs_entry: one reservation-station slot with CDB capture; RS_CDB_WAKEUP_BYPASS_EN enables same-cycle wakeup
module alu_rs_entry
    import alu_rs_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic wr,
    input  logic [$bits(rs_entry_t)-1:0] wr_data,
    input  logic issue,
    input  logic cdb_valid,
    input  logic [RS_TAG_W-1:0] cdb_tag,
    input  logic [RS_DATA_W-1:0] cdb_data,
    output logic valid,
    output logic ready,
    output logic [2:0] funct3,
    output logic [6:0] funct7,
    output logic uses_imm,
    output logic [RS_TAG_W-1:0] dest_tag,
    output logic [RS_DATA_W-1:0] lhs,
    output logic [RS_DATA_W-1:0] rhs
);
    rs_entry_t e, in, nxt;
    logic in_rhs_rdy, in_lhs_hit, in_rhs_hit, lhs_hit, rhs_hit;
    assign in = rs_entry_t'(wr_data);
    assign in_rhs_rdy = in.rhs_rdy | in.uses_imm;
    assign in_lhs_hit = cdb_valid & ~in.lhs_rdy & (cdb_tag == in.lhs_tag);
    assign in_rhs_hit = cdb_valid & ~in_rhs_rdy & (cdb_tag == in.rhs_tag);
    assign lhs_hit = e.valid & ~e.lhs_rdy & cdb_valid & (cdb_tag == e.lhs_tag);
    assign rhs_hit = e.valid & ~e.rhs_rdy & cdb_valid & (cdb_tag == e.rhs_tag);
    always_comb begin
        nxt = in;
        nxt.valid = 1'b1;
        nxt.lhs_rdy = in.lhs_rdy | in_lhs_hit;
        nxt.rhs_rdy = in_rhs_rdy | in_rhs_hit;
        nxt.lhs = in_lhs_hit ? cdb_data : in.lhs;
        nxt.rhs = in_rhs_hit ? cdb_data : in.rhs;
    end
    // a slot is only written while free and only issued while valid, so wr and issue never coincide
    always_ff @(posedge clk) begin
        if (rst || clear) e <= '0;
        else if (wr) e <= nxt;
        else if (issue) e.valid <= 1'b0;
        else begin
            if (lhs_hit) begin
                e.lhs <= cdb_data;
                e.lhs_rdy <= 1'b1;
            end
            if (rhs_hit) begin
                e.rhs <= cdb_data;
                e.rhs_rdy <= 1'b1;
            end
        end
    end
`ifdef RS_CDB_WAKEUP_BYPASS_EN
    assign ready = e.valid & (e.lhs_rdy | lhs_hit) & (e.rhs_rdy | rhs_hit);
    assign lhs = lhs_hit ? cdb_data : e.lhs;
    assign rhs = rhs_hit ? cdb_data : e.rhs;
`else
    assign ready = e.valid & e.lhs_rdy & e.rhs_rdy;
    assign lhs = e.lhs;
    assign rhs = e.rhs;
`endif
    assign valid = e.valid;
    assign funct3 = e.funct3;
    assign funct7 = e.funct7;
    assign uses_imm = e.uses_imm;
    assign dest_tag = e.dest_tag;
endmodule

// File: rtl/alu_reservation_station.sv
// alu_reservation_station: DEPTH-entry ALU issue buffer with CDB operand capture; RS_CDB_WAKEUP_BYPASS_EN enables 0-cycle wakeup
module alu_reservation_station
    import alu_rs_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int TAG_WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  logic [2:0] in_funct3,
    input  logic [6:0] in_funct7,
    input  logic in_uses_imm,
    input  logic [DATA_WIDTH-1:0] in_lhs,
    input  logic [DATA_WIDTH-1:0] in_rhs,
    input  logic in_lhs_rdy,
    input  logic in_rhs_rdy,
    input  logic [TAG_WIDTH-1:0] in_lhs_tag,
    input  logic [TAG_WIDTH-1:0] in_rhs_tag,
    input  logic [TAG_WIDTH-1:0] in_dest_tag,
    input  logic cdb_valid,
    input  logic [TAG_WIDTH-1:0] cdb_tag,
    input  logic [DATA_WIDTH-1:0] cdb_data,
    output logic out_valid,
    input  logic out_ready,
    output logic [DATA_WIDTH-1:0] out_lhs,
    output logic [DATA_WIDTH-1:0] out_rhs,
    output logic [2:0] out_funct3,
    output logic [6:0] out_funct7,
    output logic out_uses_imm,
    output logic [TAG_WIDTH-1:0] out_dest_tag,
    output logic [$clog2(DEPTH):0] count
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    rs_entry_t din;
    logic [DEPTH-1:0] valid, ready;
    logic [DEPTH-1:0][2:0] f3;
    logic [DEPTH-1:0][6:0] f7;
    logic [DEPTH-1:0] imm;
    logic [DEPTH-1:0][TAG_WIDTH-1:0] dest;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] lhs, rhs;
    logic [IW-1:0] alloc, sel;
    logic dispatch, issue;
    always_comb begin
        din = '0;
        din.valid = 1'b1;
        din.funct3 = in_funct3;
        din.funct7 = in_funct7;
        din.uses_imm = in_uses_imm;
        din.dest_tag = in_dest_tag;
        din.lhs = in_lhs;
        din.lhs_rdy = in_lhs_rdy;
        din.lhs_tag = in_lhs_tag;
        din.rhs = in_rhs;
        din.rhs_rdy = in_rhs_rdy;
        din.rhs_tag = in_rhs_tag;
    end
    // descending scan so the lowest free / lowest ready index wins
    always_comb begin
        alloc = '0;
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            alloc = valid[i] ? alloc : IW'(i);
            sel = ready[i] ? IW'(i) : sel;
        end
    end
    assign in_ready = ~&valid;
    assign out_valid = |ready;
    assign dispatch = in_valid & in_ready & ~flush;
    assign issue = out_valid & out_ready;
    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_entry
            alu_rs_entry u_entry (
                .clk(clk),
                .rst(rst),
                .clear(flush),
                .wr(dispatch && alloc == IW'(i)),
                .wr_data(din),
                .issue(issue && sel == IW'(i)),
                .cdb_valid(cdb_valid),
                .cdb_tag(cdb_tag),
                .cdb_data(cdb_data),
                .valid(valid[i]),
                .ready(ready[i]),
                .funct3(f3[i]),
                .funct7(f7[i]),
                .uses_imm(imm[i]),
                .dest_tag(dest[i]),
                .lhs(lhs[i]),
                .rhs(rhs[i])
            );
        end
    endgenerate
    assign out_lhs = out_valid ? lhs[sel] : '0;
    assign out_rhs = out_valid ? rhs[sel] : '0;
    assign out_funct3 = out_valid ? f3[sel] : '0;
    assign out_funct7 = out_valid ? f7[sel] : '0;
    assign out_uses_imm = out_valid & imm[sel];
    assign out_dest_tag = out_valid ? dest[sel] : '0;
    always_ff @(posedge clk) begin
        if (rst || flush) count <= '0;
        else count <= count + CW'(dispatch) - CW'(issue);
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// tb_alu_reservation_station: directed stimulus checked each cycle against a slot-array model of the station
module tb_alu_reservation_station;
    import alu_rs_pkg::*;
    localparam int D = 4;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1, flush = 1'b0, in_valid = 1'b0, in_ready;
    logic [2:0] in_funct3 = '0;
    logic [6:0] in_funct7 = '0;
    logic in_uses_imm = 1'b0;
    logic [63:0] in_lhs = '0, in_rhs = '0;
    logic in_lhs_rdy = 1'b0, in_rhs_rdy = 1'b0;
    logic [3:0] in_lhs_tag = '0, in_rhs_tag = '0, in_dest_tag = '0;
    logic cdb_valid = 1'b0;
    logic [3:0] cdb_tag = '0;
    logic [63:0] cdb_data = '0;
    logic out_valid, out_ready = 1'b0, out_uses_imm;
    logic [63:0] out_lhs, out_rhs;
    logic [2:0] out_funct3;
    logic [6:0] out_funct7;
    logic [3:0] out_dest_tag;
    logic [2:0] count;

    alu_reservation_station dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_uses_imm(in_uses_imm),
        .in_lhs(in_lhs), .in_rhs(in_rhs), .in_lhs_rdy(in_lhs_rdy), .in_rhs_rdy(in_rhs_rdy),
        .in_lhs_tag(in_lhs_tag), .in_rhs_tag(in_rhs_tag), .in_dest_tag(in_dest_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_lhs(out_lhs), .out_rhs(out_rhs),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_uses_imm(out_uses_imm),
        .out_dest_tag(out_dest_tag), .count(count)
    );

    int total = 0, bad = 0;
    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // model: plain slot arrays, filled lowest-free-first, emptied by issue
    logic mv[D], mimm[D], mlr[D], mrr[D];
    logic [2:0] mf3[D];
    logic [6:0] mf7[D];
    logic [3:0] mdest[D], mlt[D], mrt[D];
    logic [63:0] ml[D], mr[D];
    bit chk_en = 0;
    initial for (int i = 0; i < D; i++) mv[i] = 1'b0;

    function automatic bit lw(int i);
        return mv[i] && !mlr[i] && cdb_valid && cdb_tag == mlt[i];
    endfunction
    function automatic bit rw(int i);
        return mv[i] && !mrr[i] && cdb_valid && cdb_tag == mrt[i];
    endfunction
    function automatic bit m_ready(int i);
`ifdef RS_CDB_WAKEUP_BYPASS_EN
        return mv[i] && (mlr[i] || lw(i)) && (mrr[i] || rw(i));
`else
        return mv[i] && mlr[i] && mrr[i];
`endif
    endfunction
    function automatic logic [63:0] m_lhs(int i);
`ifdef RS_CDB_WAKEUP_BYPASS_EN
        return lw(i) ? cdb_data : ml[i];
`else
        return ml[i];
`endif
    endfunction
    function automatic logic [63:0] m_rhs(int i);
`ifdef RS_CDB_WAKEUP_BYPASS_EN
        return rw(i) ? cdb_data : mr[i];
`else
        return mr[i];
`endif
    endfunction
    function automatic int m_sel();
        for (int i = 0; i < D; i++) if (m_ready(i)) return i;
        return -1;
    endfunction

    always @(posedge clk) begin : model_update
        automatic int s;
        automatic int fr;
        automatic bit lh, rh, rr;
        s = m_sel();
        fr = -1;
        for (int i = D - 1; i >= 0; i--) if (!mv[i]) fr = i;
        if (rst) chk_en <= 1;
        if (rst || flush) begin
            for (int i = 0; i < D; i++) mv[i] <= 1'b0;
        end else begin
            for (int i = 0; i < D; i++) begin
                if (lw(i)) begin ml[i] <= cdb_data; mlr[i] <= 1'b1; end
                if (rw(i)) begin mr[i] <= cdb_data; mrr[i] <= 1'b1; end
            end
            if (s >= 0 && out_ready) mv[s] <= 1'b0;
            if (in_valid && fr >= 0) begin
                rr = in_rhs_rdy || in_uses_imm;
                lh = !in_lhs_rdy && cdb_valid && cdb_tag == in_lhs_tag;
                rh = !rr && cdb_valid && cdb_tag == in_rhs_tag;
                mv[fr] <= 1'b1;
                mf3[fr] <= in_funct3;
                mf7[fr] <= in_funct7;
                mimm[fr] <= in_uses_imm;
                mdest[fr] <= in_dest_tag;
                mlr[fr] <= in_lhs_rdy || lh;
                mrr[fr] <= rr || rh;
                mlt[fr] <= in_lhs_tag;
                mrt[fr] <= in_rhs_tag;
                ml[fr] <= lh ? cdb_data : in_lhs;
                mr[fr] <= rh ? cdb_data : in_rhs;
            end
        end
    end

    always @(negedge clk) begin : compare
        automatic int s;
        automatic int n;
        automatic bit fr;
        if (chk_en) begin
            s = m_sel();
            n = 0;
            fr = 0;
            for (int i = 0; i < D; i++) begin
                n += int'(mv[i]);
                fr |= !mv[i];
            end
            check("out_valid", out_valid, 64'(s >= 0));
            check("in_ready", in_ready, 64'(fr));
            check("count", count, 64'(n));
            check("out_lhs", out_lhs, s >= 0 ? m_lhs(s) : 64'd0);
            check("out_rhs", out_rhs, s >= 0 ? m_rhs(s) : 64'd0);
            check("out_funct3", out_funct3, s >= 0 ? 64'(mf3[s]) : 64'd0);
            check("out_funct7", out_funct7, s >= 0 ? 64'(mf7[s]) : 64'd0);
            check("out_uses_imm", out_uses_imm, s >= 0 ? 64'(mimm[s]) : 64'd0);
            check("out_dest_tag", out_dest_tag, s >= 0 ? 64'(mdest[s]) : 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask
    task automatic look();
        @(negedge clk);
        #1;
    endtask
    task automatic disp(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                        input logic [63:0] l, input logic lr, input logic [3:0] lt,
                        input logic [63:0] r, input logic rr, input logic [3:0] rt,
                        input logic [3:0] d);
        in_valid = 1'b1;
        in_funct3 = f3;
        in_funct7 = f7;
        in_uses_imm = imm;
        in_lhs = l;
        in_lhs_rdy = lr;
        in_lhs_tag = lt;
        in_rhs = r;
        in_rhs_rdy = rr;
        in_rhs_tag = rt;
        in_dest_tag = d;
    endtask
    task automatic cdb(input logic v, input logic [3:0] t, input logic [63:0] x);
        cdb_valid = v;
        cdb_tag = t;
        cdb_data = x;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        look();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_count", count, 0);
        disp(ADD, F7_BASE, 0, 5, 1, 0, 7, 1, 0, 1);
        step();
        in_valid = 1'b0;
        look();
        check("add_valid", out_valid, 1);
        check("add_lhs", out_lhs, 5);
        check("add_rhs", out_rhs, 7);
        check("add_funct3", out_funct3, 0);
        out_ready = 1'b1;
        step();
        look();
        check("add_issued", count, 0);
        disp(ADD, F7_ALT, 0, 0, 0, 3, 2, 1, 0, 2);
        step();
        in_valid = 1'b0;
        step();
        cdb(1, 3, 'h10);
        look();
`ifdef RS_CDB_WAKEUP_BYPASS_EN
        check("sub_bypass_valid", out_valid, 1);
        check("sub_bypass_lhs", out_lhs, 'h10);
`else
        check("sub_not_yet", out_valid, 0);
`endif
        step();
        cdb(0, 0, 0);
        look();
`ifdef RS_CDB_WAKEUP_BYPASS_EN
        check("sub_bypass_gone", count, 0);
`else
        check("sub_valid", out_valid, 1);
        check("sub_lhs", out_lhs, 'h10);
        check("sub_funct7", out_funct7, 'h20);
`endif
        step();
        look();
        check("sub_done", count, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(SLT, F7_BASE, 0, 0, 0, 4'(5 + i), 1, 1, 0, 4'(i));
            step();
        end
        disp(OR, F7_BASE, 0, 1, 1, 0, 1, 1, 0, 15);
        look();
        check("full_in_ready", in_ready, 0);
        check("full_count", count, 4);
        step();
        in_valid = 1'b0;
        cdb(1, 5, 'h55);
        step();
        cdb(0, 0, 0);
        out_ready = 1'b1;
        in_valid = 1'b1;
        look();
        check("full_issue_valid", out_valid, 1);
        check("full_issue_in_ready", in_ready, 0);
        check("full_issue_lhs", out_lhs, 'h55);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        look();
        check("after_issue_in_ready", in_ready, 1);
        check("after_issue_count", count, 3);
        flush = 1'b1;
        disp(AND, F7_BASE, 0, 1, 1, 0, 1, 1, 0, 14);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        look();
        check("flush_count", count, 0);
        check("flush_valid", out_valid, 0);
        step();
        look();
        check("flush_dropped", count, 0);
        out_ready = 1'b1;
        disp(XOR, F7_BASE, 0, 1, 1, 0, 0, 0, 9, 3);
        cdb(1, 9, 'hAB);
        step();
        in_valid = 1'b0;
        cdb(0, 0, 0);
        look();
        check("coll_valid", out_valid, 1);
        check("coll_rhs", out_rhs, 'hAB);
        check("coll_dest", out_dest_tag, 3);
        step();
        look();
        check("coll_issued", count, 0);
        out_ready = 1'b0;
        disp(SR, F7_ALT, 1, 'h40, 1, 0, 3, 0, 0, 6);
        step();
        in_valid = 1'b0;
        look();
        check("imm_valid", out_valid, 1);
        check("imm_flag", out_uses_imm, 1);
        check("imm_rhs", out_rhs, 3);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        disp(ADD, F7_BASE, 0, 'h100, 1, 0, 1, 1, 0, 10);
        step();
        disp(ADD, F7_BASE, 0, 0, 0, 12, 1, 1, 0, 11);
        step();
        disp(ADD, F7_BASE, 0, 'h300, 1, 0, 1, 1, 0, 12);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            look();
            check("prio_hold_dest", out_dest_tag, 10);
            check("prio_hold_lhs", out_lhs, 'h100);
            step();
        end
        out_ready = 1'b1;
        look();
        check("prio_first", out_dest_tag, 10);
        step();
        look();
        check("prio_second", out_dest_tag, 12);
        check("prio_second_lhs", out_lhs, 'h300);
        step();
        look();
        check("prio_drained", out_valid, 0);
        check("prio_left", count, 1);
        disp(ADD, F7_BASE, 0, 'h77, 1, 0, 1, 1, 0, 13);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        look();
        check("midrst_pre", out_valid, 1);
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        look();
        check("midrst_count", count, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_lhs", out_lhs, 0);
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
